// File: rtl/rv32i_pkg.sv
// Shared rv32i constants: datapath width, data-memory depth and result-source encodings.
package rv32i_pkg;

    localparam int DPW        = 32;
    localparam int DMEM_DEPTH = 64;

    localparam logic RES_ALU = 1'b0;
    localparam logic RES_MEM = 1'b1;

    // Word accesses must have both low byte-address bits clear.
    function automatic logic word_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Single-port data memory: synchronous write, synchronous read-first read.
module data_mem
    import rv32i_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic           rd_zero,
    input  logic [AW-1:0]  idx,
    input  logic [DPW-1:0] wdata,
    output logic [DPW-1:0] rdata
);

    logic [DPW-1:0] mem_r [DEPTH];
    logic [DPW-1:0] rdata_r;

    // Array write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[idx] <= wdata;
        end
    end

    // Read register samples the old word on a same-index write (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {DPW{1'b0}};
        end else if (rd_zero) begin
            rdata_r <= {DPW{1'b0}};
        end else begin
            rdata_r <= mem_r[idx];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mem_wb_stage.sv
// rv32i memory + writeback stages: data memory access, M->W registers and the
// register-file write port.
module mem_wb_stage
    import rv32i_pkg::*;
#(
    parameter int ADW   = 5,
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           regwriteM,
    input  logic           resultsrcM,
    input  logic           memwriteM,
    input  logic [DPW-1:0] aluresultM,
    input  logic [DPW-1:0] Rd2M,
    input  logic [4:0]     RdM,
    output logic [ADW-1:0] addr_3,
    output logic [DPW-1:0] wd_3,
    output logic           we,
    output logic           mem_fault
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]  idx_s;
    logic           misal_s;
    logic           oor_s;
    logic           acc_s;
    logic           fault_s;
    logic           store_s;
    logic           we_next_s;
    logic [DPW-1:0] rdata_s;
    logic [DPW-1:0] result_s;

    logic           resultsrc_w_r;
    logic [DPW-1:0] aluresult_w_r;
    logic [ADW-1:0] rd_w_r;
    logic           fault_w_r;
    logic           we_w_r;

    // M-stage address decode and fault detection.
    always_comb begin
        idx_s     = aluresultM[AW+1:2];
        misal_s   = word_misaligned(aluresultM[1:0]);
        oor_s     = |aluresultM[DPW-1:AW+2];
        acc_s     = memwriteM | (regwriteM & (resultsrcM == RES_MEM));
        fault_s   = acc_s & (misal_s | oor_s);
        store_s   = memwriteM & ~fault_s & ~rst;
        // The write enable is resolved in M so that we leaves a flop directly.
        we_next_s = regwriteM & (RdM != 5'd0) & ~(fault_s & (resultsrcM == RES_MEM));
    end

    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (store_s),
        .rd_zero (fault_s),
        .idx     (idx_s),
        .wdata   (Rd2M),
        .rdata   (rdata_s)
    );

    // M->W pipeline registers, loaded every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resultsrc_w_r <= 1'b0;
            aluresult_w_r <= {DPW{1'b0}};
            rd_w_r        <= {ADW{1'b0}};
            fault_w_r     <= 1'b0;
            we_w_r        <= 1'b0;
        end else begin
            resultsrc_w_r <= resultsrcM;
            aluresult_w_r <= aluresultM;
            rd_w_r        <= RdM[ADW-1:0];
            fault_w_r     <= fault_s;
            we_w_r        <= we_next_s;
        end
    end

    // Writeback result select.
    always_comb begin
        result_s = aluresult_w_r;
        if (resultsrc_w_r == RES_MEM) begin
            result_s = rdata_s;
        end else begin
            result_s = aluresult_w_r;
        end
    end

    assign addr_3    = rd_w_r;
    assign wd_3      = result_s;
    assign we        = we_w_r;
    assign mem_fault = fault_w_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized checks of mem_wb_stage against an array-based memory model.
module tb_mem_wb_stage;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwriteM;
    logic        resultsrcM;
    logic        memwriteM;
    logic [31:0] aluresultM;
    logic [31:0] Rd2M;
    logic [4:0]  RdM;
    logic [4:0]  addr_3;
    logic [31:0] wd_3;
    logic        we;
    logic        mem_fault;

    logic [31:0] mem_m [DEPTH];
    int          n_chk = 0;
    int          n_bad = 0;

    mem_wb_stage #(.ADW(5), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .regwriteM  (regwriteM),
        .resultsrcM (resultsrcM),
        .memwriteM  (memwriteM),
        .aluresultM (aluresultM),
        .Rd2M       (Rd2M),
        .RdM        (RdM),
        .addr_3     (addr_3),
        .wd_3       (wd_3),
        .we         (we),
        .mem_fault  (mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one M bundle, predict W outputs from the word model, check after the edge.
    task automatic issue(input logic r, input logic rw, input logic rs, input logic mw,
                         input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] rd);
        logic        flt;
        logic [31:0] e_wd;
        logic        e_we;
        logic [4:0]  e_addr;
        int unsigned w;
        rst = r; regwriteM = rw; resultsrcM = rs; memwriteM = mw;
        aluresultM = alu; Rd2M = d2; RdM = rd;
        w   = (alu / 4) % DEPTH;
        flt = (mw || (rw && rs)) && ((alu % 4) != 0 || alu >= 32'(4 * DEPTH));
        if (r) begin
            e_wd = 32'd0; e_we = 1'b0; e_addr = 5'd0; flt = 1'b0;
        end else begin
            e_addr = rd;
            e_wd   = rs ? (flt ? 32'd0 : mem_m[w]) : alu;
            e_we   = rw && (rd != 5'd0) && !(flt && rs);
            if (mw && !flt) mem_m[w] = d2;
        end
        @(posedge clk);
        #1;
        chk("addr_3", {27'd0, addr_3}, {27'd0, e_addr});
        chk("wd_3", wd_3, e_wd);
        chk("we", {31'd0, we}, {31'd0, e_we});
        chk("mem_fault", {31'd0, mem_fault}, {31'd0, flt});
    endtask

    initial begin
        int unsigned sel;
        int unsigned cls;
        logic [31:0] a;

        // Reset state.
        issue(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 5'd3);

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b0, 1'b0, 1'b0, 1'b1, 32'(i * 4), $urandom, 5'($urandom_range(0, 31)));
        end

        // ALU result writeback.
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'd0, 5'd5);
        chk("alu_wd", wd_3, 32'h0000_1234);

        // Store then load in consecutive cycles.
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0);
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 5'd7);
        chk("st_ld_wd", wd_3, 32'hDEAD_BEEF);

        // Read-first collision on one index.
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h11, 5'd0);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h22, 5'd9);
        chk("rdfirst_old", wd_3, 32'h11);
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 5'd9);
        chk("rdfirst_new", wd_3, 32'h22);

        // Misaligned store: dropped, one-cycle fault pulse.
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h13, 32'hBAD0_BAD0, 5'd0);
        chk("mis_pulse", {31'd0, mem_fault}, 32'd1);
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 5'd4);
        chk("mis_unchanged", wd_3, 32'h22);

        // Out-of-range load.
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'd0, 5'd6);
        chk("oor_we", {31'd0, we}, 32'd0);

        // x0 writes suppressed.
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 5'd0);
        chk("x0_wd", wd_3, 32'hFFFF_FFFF);

        // Reset with a store in M.
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h55, 5'd0);
        issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'hAA, 5'd0);
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 32'd0, 5'd2);
        chk("rst_store_dropped", wd_3, 32'h55);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
            else if (sel == 7) a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
            else if (sel == 8) a = 32'($urandom_range(256, 4096));
            else               a = $urandom;
            cls = $urandom_range(0, 2);
            issue(($urandom_range(0, 49) == 0), (cls != 2), (cls == 1), (cls == 2),
                  (cls == 0) ? $urandom : a, $urandom, 5'($urandom_range(0, 31)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory and writeback stages of the rv32i pipeline.
- Consumes the M-stage bundle produced by the execute stage: regwriteM, resultsrcM, memwriteM, aluresultM, Rd2M, RdM.
- Performs word stores and loads against an internal data memory, registers the M→W boundary, and selects the result.
- Drives the register-file write port (addr_3, wd_3, we), closing the loop back into the decode stage.

Parameters:
- ADW, 5, register-file address width; equals the width of addr_3.
- DEPTH, 64, data memory depth in 32-bit words; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- regwriteM  in  1  the instruction writes a register.
- resultsrcM  in  1  result source select: 1 = load data, 0 = ALU result.
- memwriteM  in  1  store enable.
- aluresultM  in  DPW  byte address for load/store, or the ALU result.
- Rd2M  in  DPW  store data.
- RdM  in  5  destination register.
- addr_3  out  ADW  register-file write address; equals RdW[ADW-1:0].
- wd_3  out  DPW  register-file write data; equals resultW.
- we  out  1  register-file write enable.
- mem_fault  out  1  one-cycle pulse in W for a faulting load or store.

Behaviour:
- Derived M-stage signals:
  - idxM = aluresultM[$clog2(DEPTH)+1:2].
  - misalM = (aluresultM[1:0] != 0).
  - oorM = (aluresultM[DPW-1:$clog2(DEPTH)+2] != 0).
  - accM = memwriteM | (regwriteM & resultsrcM).
  - faultM = accM & (misalM | oorM).
- Store:
  - mem[idxM] <= Rd2M at the rising edge when memwriteM & !faultM & !rst.
  - Faulting stores and stores during reset are dropped; memory is unchanged.
- Load:
  - Synchronous read; rdataW <= mem[idxM] at the same edge the W registers load.
  - Latency is 1 cycle, aligned with W.
  - A faulting load captures rdataW = 0.
- Read-during-write to the same index: read-first, so rdataW returns the old word.
- W pipeline registers, loaded every cycle (no stall or flush in this revision): regwriteW, resultsrcW, aluresultW, RdW, faultW.
- On rst, all W registers clear to 0, so addr_3 = 0, wd_3 = 0, we = 0, mem_fault = 0 from the cycle after rst is sampled.
- Memory contents are not reset.
- resultW = resultsrcW ? rdataW : aluresultW.
- we = regwriteW & (RdW != 0) & !(faultW & resultsrcW).
  - Writes to x0 are always suppressed.
  - A faulting load never writes the register file.
- mem_fault = faultW.
- Total latency from the M inputs to addr_3/wd_3/we is exactly 1 clock.
- Back-to-back store then load to the same address in consecutive cycles: the load sees the stored data, because the store committed at the previous edge.
- Reset mid-stream: an instruction present in M during the rst cycle is discarded and produces no W output.
- Word-access only; byte and halfword access are out of scope for this revision.

Decomposition:
- rv32i_pkg additions:
  - DMEM_DEPTH default constant (64).
  - RES_ALU = 1'b0 and RES_MEM = 1'b1 encodings for resultsrc.
- DPW stays in rv32i_pkg.
- One sub-module, data_mem (DEPTH × DPW, synchronous write, synchronous read-first read, single port), instantiated as u_data_mem.
- Fault logic, W registers and the result mux stay in mem_wb_stage.

Test Plan:
- ALU op: regwriteM=1, resultsrcM=0, aluresultM=0x0000_1234, RdM=5 → next cycle addr_3=5, wd_3=0x0000_1234, we=1, mem_fault=0.
- Store then load: cycle 0 memwriteM=1, aluresultM=0x10, Rd2M=0xDEAD_BEEF; cycle 1 regwriteM=1, resultsrcM=1, aluresultM=0x10, RdM=7 → cycle 2 addr_3=7, wd_3=0xDEAD_BEEF, we=1.
- Read-first collision: mem[4]=0x11 preloaded; a store of 0x22 to 0x10 and a load from 0x10 overlap in one cycle → wd_3=0x11; a second load returns 0x22.
- Faults:
  - Store to 0x13 (misaligned) → mem unchanged, mem_fault pulses 1 for one cycle.
  - Load from 0x100 (out of range, DEPTH=64) → we=0, mem_fault=1.
- x0 suppression: regwriteM=1, RdM=0, aluresultM=0xFFFF_FFFF → we=0, wd_3=0xFFFF_FFFF.
- Reset mid-stream: rst=1 while a store of 0xAA to 0x8 is in M → mem[2] unchanged; next cycle we=0, addr_3=0, wd_3=0, mem_fault=0.
